mem_arbiter: RTL and testbench

- Parametrised N-port memory arbiter between pipeline memory clients and one shared memory bus.
- Typical clients: instruction fetch, data access, debug.
- Accepts one request at a time and holds it on the bus until the memory acknowledges or a timeout fires, then returns a one-cycle response to the requester.
- Supports round-robin or fixed-priority arbitration, and replaces clock-gated stalls with explicit per-port ready/response handshakes.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/rr_picker.sv | 44 ++++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_pkg - shared encodings for the memory arbiter (rev 1.0)
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  localparam int CNT_W = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_picker - combinational round-robin / fixed-priority request picker (rev 1.0)
// ----------------------------------------------------------------------------
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             mode_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Visit ports in search order; the first requester seen wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, start_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = (mode_i == PRIO_FIXED) ? IDX_W'(i) : sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter - N-port arbiter onto one shared memory bus with timeout (rev 1.0)
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 15
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_PORTS-1:0]            i_req_valid,
  input  logic [NUM_PORTS-1:0]            i_req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     i_req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] i_req_be,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            rsp_err,
  output logic                            mem_valid,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_be,
  input  logic                            i_mem_ready,
  input  logic [DATA_W-1:0]               i_mem_rdata,
  output logic                            busy
);

  localparam int   BE_W      = DATA_W / 8;
  localparam int   IDX_W     = idx_width(NUM_PORTS);
  localparam logic PICK_MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     gidx;
  logic                 accept;
  logic                 finish;

  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [BE_W-1:0]      be_q;
  logic [NUM_PORTS-1:0] port_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BE_W-1:0]      sel_be;

  rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (i_req_valid),
    .start_i (rr_q),
    .mode_i  (PICK_MODE),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_we    = i_req_we[p];
        sel_addr  = i_req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[p*DATA_W +: DATA_W];
        sel_be    = i_req_be[p*BE_W +: BE_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RESP accepts exactly like IDLE so transfers can run back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (|i_req_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_ready || (cnt_d == CNT_W'(TIMEOUT))) begin
          finish  = 1'b1;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      rr_d = (gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx + IDX_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // req_ready is masked by reset so every output reads zero while it is held.
  always_comb begin
    req_ready = accept ? (grant & {NUM_PORTS{i_rst}}) : '0;
    rsp_valid = (state_q == ST_RESP) ? port_q : '0;
    mem_valid = (state_q == ST_BUSY);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      port_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
        port_q  <= grant;
      end
      if (finish) begin
        err_q   <= !i_mem_ready;
        rdata_q <= (i_mem_ready && !we_q) ? i_mem_rdata : '0;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter - directed self-checking bench for mem_arbiter (rev 1.0)
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int RR = 0;
  localparam int FX = 1;
  localparam int TO = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [1:0]  rdy    [3];
  logic [1:0]  rsp_v  [3];
  logic [31:0] rsp_rd [3];
  logic        rsp_e  [3];
  logic        mv     [3];
  logic        mwe    [3];
  logic [31:0] maddr  [3];
  logic [31:0] mwdata [3];
  logic [3:0]  mbe    [3];
  logic        bsy    [3];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(15)) u_rr (
    .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .req_ready(rdy[RR]), .rsp_valid(rsp_v[RR]), .rsp_rdata(rsp_rd[RR]), .rsp_err(rsp_e[RR]),
    .mem_valid(mv[RR]), .mem_we(mwe[RR]), .mem_addr(maddr[RR]), .mem_wdata(mwdata[RR]),
    .mem_be(mbe[RR]), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .busy(bsy[RR])
  );

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(15)) u_fx (
    .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .req_ready(rdy[FX]), .rsp_valid(rsp_v[FX]), .rsp_rdata(rsp_rd[FX]), .rsp_err(rsp_e[FX]),
    .mem_valid(mv[FX]), .mem_we(mwe[FX]), .mem_addr(maddr[FX]), .mem_wdata(mwdata[FX]),
    .mem_be(mbe[FX]), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .busy(bsy[FX])
  );

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(3)) u_to (
    .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .req_ready(rdy[TO]), .rsp_valid(rsp_v[TO]), .rsp_rdata(rsp_rd[TO]), .rsp_err(rsp_e[TO]),
    .mem_valid(mv[TO]), .mem_we(mwe[TO]), .mem_addr(maddr[TO]), .mem_wdata(mwdata[TO]),
    .mem_be(mbe[TO]), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .busy(bsy[TO])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state, with requests present to show req_ready stays low.
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_req_ready", rdy[RR], 2'b00);
    check("rst_mem_valid", mv[RR], 1'b0);
    check("rst_busy", bsy[RR], 1'b0);
    check("rst_rsp_valid", rsp_v[RR], 2'b00);
    tick();
    req_valid = '0;
    rst_n     = 1'b1;

    // Single read from port 1.
    tick();
    req_valid       = 2'b10;
    req_addr[63:32] = 32'h100;
    @(negedge clk);
    check("t1_req_ready", rdy[FX], 2'b10);
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_mem_valid", mv[FX], 1'b1);
    check("t1_mem_addr", maddr[FX], 32'h100);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("t1_rsp_valid", rsp_v[FX], 2'b10);
    check("t1_rsp_rdata", rsp_rd[FX], 32'hDEADBEEF);
    check("t1_rsp_err", rsp_e[FX], 1'b0);
    tick();
    @(negedge clk);
    check("t1_rsp_done", rsp_v[FX], 2'b00);
    check("t1_idle", bsy[FX], 1'b0);

    // Contention with zero-wait memory: rr alternates, fixed always port 0.
    tick();
    req_valid = 2'b11;
    mem_ready = 1'b1;
    mem_rdata = 32'h5A5A0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_rr_grant", rdy[RR], (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_fx_grant", rdy[FX], 2'b01);
      if (k > 0) check("t2_rr_rsp", rsp_v[RR], ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
      check("t2_busy_noready", rdy[RR], 2'b00);
      tick();
    end
    @(negedge clk);
    check("t2_rr_last_rsp", rsp_v[RR], 2'b10);
    check("t2_fx_last_rsp", rsp_v[FX], 2'b01);

    // Timeout on the TIMEOUT=3 instance; read data on the bus must be ignored.
    tick();
    mem_ready       = 1'b0;
    req_valid       = 2'b01;
    req_addr[31:0]  = 32'h300;
    mem_rdata       = 32'hBAD0BAD0;
    @(negedge clk);
    check("t3_req_ready", rdy[TO], 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t3_mem_valid", mv[TO], 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("t3_no_early_rsp", rsp_v[TO], 2'b00);
    check("t3_still_busy", mv[TO], 1'b1);
    tick();
    @(negedge clk);
    check("t3_rsp_valid", rsp_v[TO], 2'b01);
    check("t3_rsp_err", rsp_e[TO], 1'b1);
    check("t3_rsp_rdata", rsp_rd[TO], 32'h0);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check("t3_idle_after", bsy[TO], 1'b0);
    check("t3_single_pulse", rsp_v[TO], 2'b00);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("t3_rr_ack_rsp", rsp_v[RR], 2'b01);
    check("t3_rr_ack_err", rsp_e[RR], 1'b0);

    // Wait states: ready arrives 4 cycles after mem_valid rises.
    tick();
    req_valid      = 2'b01;
    req_addr[31:0] = 32'h200;
    mem_rdata      = 32'hCAFEF00D;
    @(negedge clk);
    check("t4_req_ready", rdy[RR], 2'b01);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) req_valid = 2'b00;
      @(negedge clk);
      check("t4_mem_valid", mv[RR], 1'b1);
      check("t4_mem_addr", maddr[RR], 32'h200);
      check("t4_no_rsp", rsp_v[RR], 2'b00);
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check("t4_mem_valid_last", mv[RR], 1'b1);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("t4_rsp_valid", rsp_v[RR], 2'b01);
    check("t4_rsp_rdata", rsp_rd[RR], 32'hCAFEF00D);
    check("t4_mem_valid_drop", mv[RR], 1'b0);
    tick();
    @(negedge clk);
    check("t4_rsp_once", rsp_v[RR], 2'b00);

    // Write from port 1: rdata on the bus is ignored, response data is zero.
    tick();
    req_valid        = 2'b10;
    req_we           = 2'b10;
    req_addr[63:32]  = 32'h400;
    req_wdata[63:32] = 32'h12345678;
    req_be[7:4]      = 4'b0011;
    mem_rdata        = 32'hFFFFFFFF;
    @(negedge clk);
    check("t5_req_ready", rdy[RR], 2'b10);
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    @(negedge clk);
    check("t5_mem_we", mwe[RR], 1'b1);
    check("t5_mem_be", mbe[RR], 4'b0011);
    check("t5_mem_wdata", mwdata[RR], 32'h12345678);
    check("t5_mem_addr", maddr[RR], 32'h400);
    tick();
    mem_ready = 1'b0;
    req_we    = 2'b00;
    @(negedge clk);
    check("t5_rsp_valid", rsp_v[RR], 2'b10);
    check("t5_rsp_rdata", rsp_rd[RR], 32'h0);
    check("t5_rsp_err", rsp_e[RR], 1'b0);

    // Async reset while BUSY (after a port-0 grant moved rr to 1).
    tick();
    req_valid      = 2'b01;
    req_addr[31:0] = 32'h500;
    @(negedge clk);
    check("t6_req_ready", rdy[RR], 2'b01);
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    check("t6_busy_before", mv[RR], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_mem_valid", mv[RR], 1'b0);
    check("t6_async_busy", bsy[RR], 1'b0);
    check("t6_async_mem_addr", maddr[RR], 32'h0);
    check("t6_async_req_ready", rdy[RR], 2'b00);
    check("t6_async_rsp", rsp_v[RR], 2'b00);
    tick();
    @(negedge clk);
    check("t6_in_reset_rsp", rsp_v[RR], 2'b00);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst_grant", rdy[RR], 2'b01);
    check("t6_post_rst_rsp", rsp_v[RR], 2'b00);
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000BEEF;
    @(negedge clk);
    check("t6_post_rst_busy_rsp", rsp_v[RR], 2'b00);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("t6_post_rst_rsp_valid", rsp_v[RR], 2'b01);
    check("t6_post_rst_rdata", rsp_rd[RR], 32'h0000BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
